// File: rtl/mdu_gen_pkg.sv
// mdu_gen_pkg: op codes, FSM states and op classification for the HI/LO multiply/divide unit.
// MDU_GEN_MADD_EN enables the MADD/MADDU/MSUB/MSUBU accumulate ops.
package mdu_gen_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MADD  = 4'd7,
        OP_MADDU = 4'd8,
        OP_MSUB  = 4'd9,
        OP_MSUBU = 4'd10
    } op_e;

    typedef enum logic {IDLE, RUN} state_e;

    function automatic logic is_long(input logic [3:0] op);
`ifdef MDU_GEN_MADD_EN
        return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
`else
        return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
`endif
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return op == OP_DIV || op == OP_DIVU;
    endfunction

    function automatic logic is_signed(input logic [3:0] op);
        return op inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
    endfunction

endpackage

// File: rtl/mdu_gen_core.sv
// mdu_gen_core: combinational {HI,LO} result for the registered operation.
// Signed ops work on magnitudes and fix the sign afterwards.
module mdu_gen_core
    import mdu_gen_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   hi,
    input  logic [WIDTH-1:0]   lo,
    output logic [2*WIDTH-1:0] res
);

    logic               sgn, neg, a_neg;
    logic [WIDTH-1:0]   ma, mb, q, r, qs, rs;
    logic [2*WIDTH-1:0] pmag, prod;

    always_comb begin
        sgn   = is_signed(op);
        a_neg = sgn && a[WIDTH-1];
        neg   = sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
        ma    = a_neg ? -a : a;
        mb    = (sgn && b[WIDTH-1]) ? -b : b;
        pmag  = {{WIDTH{1'b0}}, ma} * {{WIDTH{1'b0}}, mb};
        prod  = neg ? -pmag : pmag;
        q     = (mb == '0) ? '1 : ma / mb;
        r     = (mb == '0) ? '0 : ma % mb;
        // The most negative dividend by -1 falls out naturally: |MIN| / 1 wraps back to MIN.
        qs    = neg ? -q : q;
        rs    = a_neg ? -r : r;
        case (op)
            OP_MULT, OP_MULTU: res = prod;
            OP_DIV, OP_DIVU:   res = (b == '0) ? {a, {WIDTH{1'b1}}} : {rs, qs};
            OP_MADD, OP_MADDU: res = {hi, lo} + prod;
            OP_MSUB, OP_MSUBU: res = {hi, lo} - prod;
            default:           res = {hi, lo};
        endcase
    end

endmodule

// File: rtl/mdu_gen.sv
// mdu_gen: multi-cycle HI/LO multiply/divide controller with CP0 flush and MTHI/MTLO.
// MDU_GEN_MADD_EN additionally accepts the multiply-accumulate ops.
module mdu_gen
    import mdu_gen_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             Req,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    state_e             state;
    logic [7:0]         cnt;
    logic [3:0]         op_r;
    logic [WIDTH-1:0]   a, b;
    logic [2*WIDTH-1:0] res;

    mdu_gen_core #(.WIDTH(WIDTH)) u_core (
        .op  (op_r),
        .a   (a),
        .b   (b),
        .hi  (hi),
        .lo  (lo),
        .res (res)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            op_r  <= OP_NONE;
            a     <= '0;
            b     <= '0;
            hi    <= '0;
            lo    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start && !Req) begin
                    if (is_long(op)) begin
                        a     <= in1;
                        b     <= in2;
                        op_r  <= op;
                        cnt   <= is_div(op) ? 8'(DIV_CYCLES) : 8'(MULT_CYCLES);
                        state <= RUN;
                        busy  <= 1'b1;
                    end else if (op == OP_MTHI) begin
                        hi <= in1;
                    end else if (op == OP_MTLO) begin
                        lo <= in1;
                    end
                end
            end else if (Req) begin
                state <= IDLE;
                cnt   <= '0;
                busy  <= 1'b0;
            end else if (cnt == 8'd1) begin
                {hi, lo} <= res;
                state    <= IDLE;
                cnt      <= '0;
                busy     <= 1'b0;
                done     <= 1'b1;
            end else begin
                cnt <= cnt - 8'd1;
            end
        end
    end

endmodule

// File: doc/mdu_gen.md
MDU_GEN -- requirements
Module: mdu_gen

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand and HI/LO width.
REQ-002 The block SHALL have parameter MULT_CYCLES, default 5, multiply latency in cycles (legal range 1..255).
REQ-003 The block SHALL have parameter DIV_CYCLES, default 10, divide latency in cycles (legal range 1..255).
REQ-004 The block SHALL have port clk  input  1  rising-edge clock.
REQ-005 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port start  input  1  request to launch the operation on op.
REQ-007 The block SHALL have port op  input  4  operation code from the shared include.
REQ-008 The block SHALL have port in1  input  WIDTH  rs operand.
REQ-009 The block SHALL have port in2  input  WIDTH  rt operand.
REQ-010 The block SHALL have port Req  input  1  exception/interrupt flush from CP0.
REQ-011 The block SHALL have port hi  output  WIDTH  architectural HI.
REQ-012 The block SHALL have port lo  output  WIDTH  architectural LO.
REQ-013 The block SHALL have port busy  output  1  multi-cycle operation in flight.
REQ-014 The block SHALL have port done  output  1  one-cycle pulse on HI/LO commit of a multi-cycle operation.

Function
REQ-015 FSM states SHALL be IDLE and RUN; counter width SHALL be 8 bits.
REQ-016 In IDLE, a start with a MULT/MULTU/DIV/DIVU op, sampled at edge t with Req low, SHALL load operand and op registers, load the counter with MULT_CYCLES or DIV_CYCLES, enter RUN and raise busy after edge t.
REQ-017 In RUN, the counter SHALL decrement every edge; when it reaches 1, the next edge SHALL commit HI/LO, return to IDLE, drop busy and pulse done for exactly one cycle. Total busy duration SHALL be exactly N cycles.
REQ-018 MULT SHALL produce the signed 2*WIDTH product; MULTU the unsigned product; HI = upper WIDTH bits, LO = lower WIDTH bits.
REQ-019 DIV/DIVU SHALL set LO = quotient and HI = remainder; signed results SHALL truncate toward zero, and the remainder SHALL take the dividend's sign.
REQ-020 A divisor of 0 SHALL commit HI = in1 and LO = all ones.
REQ-021 Signed DIV of the most negative value by -1 SHALL commit LO = most negative value and HI = 0.
REQ-022 MTHI/MTLO with start in IDLE and Req low SHALL write in1 to HI/LO at the same edge, with no busy and no done.
REQ-023 Any start while busy SHALL be ignored; the controller stalls instead.
REQ-024 A start carrying an undefined op SHALL be ignored.
REQ-025 Req high in RUN SHALL abort at that edge: return to IDLE, leave HI/LO unchanged, no done pulse.
REQ-026 Req high coincident with start SHALL suppress the start, including MTHI/MTLO.
REQ-027 hi/lo SHALL be driven directly from registers, with no combinational path from inputs.

Reset
REQ-028 On reset low, asynchronously: state = IDLE, counter = 0, hi = 0, lo = 0, busy = 0, done = 0.
REQ-029 Reset asserted mid-operation SHALL discard the operation, with no commit and no done.

Configuration
REQ-030 With MDU_GEN_MADD_EN defined, op codes MADD, MADDU, MSUB and MSUBU SHALL be accepted with latency MULT_CYCLES, committing {HI,LO} plus or minus the product, modulo 2^(2*WIDTH).
REQ-031 Without MDU_GEN_MADD_EN, those op codes SHALL be treated as undefined and ignored per REQ-024.

Structure
REQ-032 Op codes (MULT, MULTU, DIV, DIVU, MTHI, MTLO, MADD, MADDU, MSUB, MSUBU, NONE) SHALL live in the shared MACRO.v include; encoding 0 SHALL be NONE.
REQ-033 One combinational sub-module, mdu_gen_core, SHALL compute the {HI,LO} result from the registered operands, op and current HI/LO; the FSM and counter SHALL stay in mdu_gen.

Verification
REQ-034 MULT in1=0xFFFFFFFE, in2=3 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulses once.
REQ-035 DIV in1=-7, in2=2 -> busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU in1=7, in2=0 -> hi=7, lo=0xFFFFFFFF.
REQ-036 MULTU launched, Req high at cycle 3 -> busy low next cycle, hi/lo keep prior values, no done.
REQ-037 MTHI 0x1234 during RUN is ignored; after done, MTLO 0x55 with Req high is ignored; MTLO 0x55 with Req low -> lo=0x55 the next cycle, busy stays low.
REQ-038 MDU_GEN_MADD_EN defined, hi=0, lo=0xFFFFFFFF, MADDU 1*1 -> hi=1, lo=0; macro undefined -> same stimulus ignored, busy never rises.
REQ-039 Reset low in the middle of DIV -> all outputs 0 immediately; after release, MULT 2*3 gives lo=6 after MULT_CYCLES.
